ntt_out_serializer: RTL and testbench
=====================================

NTT_OUT_SERIALIZER -- requirements
Module: ntt_out_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH_PER_INPUT, default 28, meaning coefficient width in bits.
REQ-002 The block SHALL have parameter INPUT_PER_CYCLE, default 128, meaning lanes delivered per cycle by the NTT core.
REQ-003 The block SHALL have parameter RING_DIM, default 2048, meaning coefficients per frame; ROWS = RING_DIM/INPUT_PER_CYCLE (16).
REQ-004 The block SHALL have port clk, input, 1, the single clock.
REQ-005 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 The block SHALL have port frame_start, input, 1, the core's out_start pulse marking row 0 of a result frame.
REQ-007 The block SHALL have port lane_data, input, INPUT_PER_CYCLE x DATA_WIDTH_PER_INPUT, the core result lanes.
REQ-008 The block SHALL have port m_data, output, DATA_WIDTH_PER_INPUT, the serial coefficient.
REQ-009 The block SHALL have ports m_valid (output, 1), m_ready (input, 1) and m_last (output, 1, final coefficient of frame).
REQ-010 The block SHALL have ports busy (output, 1, capture active or any bank full) and overflow (output, 1, sticky dropped-frame flag).

Function
REQ-011 The block SHALL hold two frame banks (ping-pong), each ROWS rows x INPUT_PER_CYCLE lanes.
REQ-012 The capture FSM SHALL use states C_IDLE and C_CAPTURE; frame_start in C_IDLE with a free bank SHALL capture lane_data into row 0 in that cycle T and enter C_CAPTURE.
REQ-013 The block SHALL write rows 1..ROWS-1 on cycles T+1..T+15 unconditionally, mark the bank full at end of T+15 and return to C_IDLE.
REQ-014 Coefficient index k SHALL map to row k/INPUT_PER_CYCLE, lane k%INPUT_PER_CYCLE.
REQ-015 The drain FSM SHALL use states D_IDLE and D_STREAM; a full bank SHALL raise m_valid no earlier than cycle T+16, banks draining in capture order.
REQ-016 The block SHALL transfer a coefficient only when m_valid && m_ready; m_data/m_valid/m_last SHALL be registered and held stable while m_valid && !m_ready.
REQ-017 The block SHALL emit coefficients k=0..RING_DIM-1, assert m_last with k=RING_DIM-1, then free the bank; the next full bank SHALL stream without a bubble.
REQ-018 The block SHALL ignore frame_start during C_CAPTURE and set overflow; frame_start with both banks full SHALL drop the frame and set overflow.
REQ-019 The block SHALL permit the drain to free a bank in the same cycle capture claims it, with capture seeing the bank as free.
REQ-020 The block SHALL clear overflow only by rst.

Reset
REQ-021 On rst, the block SHALL enter C_IDLE/D_IDLE, mark both banks empty, zero m_data, m_valid, m_last, busy and overflow, and discard a partial capture or drain; bank contents need not clear.

Configuration
REQ-022 With NTT_OSER_BITREV_EN defined, the output at position k SHALL carry coefficient bitrev_log2(RING_DIM)(k); without it the order SHALL be natural; framing and m_last SHALL be unchanged.

Structure
REQ-023 Package ntt_pkg SHALL hold width/size localparams, the coefficient typedef, the capture/drain state enums and the bitrev function.
REQ-024 The block SHALL use one sub-module, ntt_oser_bank: a single frame bank (row write port, registered row read plus lane mux).

Verification
REQ-025 The bench SHALL drive frame_start at T with lane value = k -> m_valid first at T+16, m_data 0..2047 in order, m_last only at 2047.
REQ-026 The bench SHALL drive a second frame_start at T+16 with m_ready=1 -> 4096 contiguous beats, no bubble, overflow=0.
REQ-027 The bench SHALL hold m_ready low for 10 cycles at k=100 -> m_data stays 100, m_valid stays 1, no loss or duplication.
REQ-028 The bench SHALL drive frame_start at T+5 during capture, or a third frame while both banks are full -> frame dropped, overflow=1 until rst.
REQ-029 The bench SHALL assert rst at k=700 of drain -> next cycle m_valid=0, busy=0, overflow=0; a new frame then streams from k=0.
REQ-030 The bench SHALL build with NTT_OSER_BITREV_EN and lane value = k -> output position 1 carries 1024, position 2047 carries 2047.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared sizes, coefficient type, FSM state encodings and index helpers
// for the NTT output serializer.
package ntt_pkg;

    localparam int NTT_DATA_WIDTH      = 28;
    localparam int NTT_INPUT_PER_CYCLE = 128;
    localparam int NTT_RING_DIM        = 2048;
    localparam int NTT_ROWS            = NTT_RING_DIM / NTT_INPUT_PER_CYCLE;
    localparam int NTT_LOG2_RING       = $clog2(NTT_RING_DIM);

    typedef logic [NTT_DATA_WIDTH-1:0] coef_t;

    typedef enum logic {
        C_IDLE    = 1'b0,
        C_CAPTURE = 1'b1
    } cap_state_t;

    typedef enum logic {
        D_IDLE   = 1'b0,
        D_STREAM = 1'b1
    } drn_state_t;

    // Reverses the low nbits of value; bits above nbits come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int nbits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) begin
                r[i] = value[nbits-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_oser_bank.sv
// One frame bank: ROWS rows of INPUT_PER_CYCLE lanes, a full-row write port
// and a registered row read followed by a lane multiplexer.
module ntt_oser_bank #(
    parameter int DATA_WIDTH_PER_INPUT = 28,
    parameter int INPUT_PER_CYCLE      = 128,
    parameter int ROWS                 = 16
) (
    input  logic                                            clk,
    input  logic                                            we,
    input  logic [$clog2(ROWS)-1:0]                         wr_row,
    input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] wr_data,
    input  logic [$clog2(ROWS)-1:0]                         rd_row,
    input  logic [$clog2(INPUT_PER_CYCLE)-1:0]              rd_lane,
    output logic [DATA_WIDTH_PER_INPUT-1:0]                 rd_data
);

    logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] mem [ROWS];
    logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] row_q;

    // The read register reloads every cycle, so a row read before its
    // write simply refreshes on the following edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_row] <= wr_data;
        end
        row_q <= mem[rd_row];
    end

    assign rd_data = row_q[rd_lane*DATA_WIDTH_PER_INPUT +: DATA_WIDTH_PER_INPUT];

endmodule

// File: rtl/ntt_out_serializer.sv
// Ping-pong frame buffer turning row-parallel NTT results into a serial coefficient stream.
// Build option: NTT_OSER_BITREV_EN emits coefficients in bit-reversed index order.
module ntt_out_serializer
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH_PER_INPUT = NTT_DATA_WIDTH,
    parameter int INPUT_PER_CYCLE      = NTT_INPUT_PER_CYCLE,
    parameter int RING_DIM             = NTT_RING_DIM
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            frame_start,
    input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] lane_data,
    output logic [DATA_WIDTH_PER_INPUT-1:0]                 m_data,
    output logic                                            m_valid,
    input  logic                                            m_ready,
    output logic                                            m_last,
    output logic                                            busy,
    output logic                                            overflow,
    output logic                                            dbg_cap_state,
    output logic                                            dbg_drn_state
);

    localparam int ROWS   = RING_DIM / INPUT_PER_CYCLE;
    localparam int ROW_W  = $clog2(ROWS);
    localparam int LANE_W = $clog2(INPUT_PER_CYCLE);
    localparam int K_W    = $clog2(RING_DIM);

    // Stream handshake: a coefficient moves on a clock edge where m_valid && m_ready;
    // m_data/m_valid/m_last are registers and stay unchanged while m_valid && !m_ready.

    function automatic logic [K_W-1:0] coef_of(input logic [K_W-1:0] k);
`ifdef NTT_OSER_BITREV_EN
        logic [31:0] r;
        r = bitrev({{(32-K_W){1'b0}}, k}, K_W);
        return r[K_W-1:0];
`else
        return k;
`endif
    endfunction

    cap_state_t          cap_state;
    logic                wr_bank;
    logic [ROW_W-1:0]    wr_row;

    drn_state_t          drn_state;
    logic                rd_bank;
    logic                out_bank;
    logic [K_W-1:0]      next_k;

    logic [1:0]          full;
    logic [1:0]          avail;
    logic [1:0]          wr_sel;
    logic [1:0]          out_sel;
    logic [1:0]          done_v;
    logic [1:0]          free_v;
    logic [1:0]          bank_we;

    logic                cap_we;
    logic                cap_done;
    logic                bank_free;
    logic [ROW_W-1:0]    cap_row;

    logic                advance;
    logic                load;
    logic                k_last;
    logic                free_fire;
    logic [K_W-1:0]      k_inc;
    logic [K_W-1:0]      cur_coef;
    logic [K_W-1:0]      nxt_coef;
    logic [ROW_W-1:0]    rd_row;
    logic [LANE_W-1:0]   rd_lane;

    logic [DATA_WIDTH_PER_INPUT-1:0] bank_rd [2];

    assign wr_sel  = wr_bank  ? 2'b10 : 2'b01;
    assign out_sel = out_bank ? 2'b10 : 2'b01;

    assign free_fire = m_valid && m_ready && m_last;
    assign free_v    = free_fire ? out_sel : 2'b00;
    // A bank released by the drain on this edge may be claimed on the same edge.
    assign bank_free = !full[wr_bank] || free_v[wr_bank];

    assign cap_done = (cap_state == C_CAPTURE) && (wr_row == ROW_W'(ROWS - 1));
    assign done_v   = cap_done ? wr_sel : 2'b00;
    assign cap_we   = ((cap_state == C_IDLE) && frame_start && bank_free) ||
                      (cap_state == C_CAPTURE);
    assign cap_row  = (cap_state == C_CAPTURE) ? wr_row : '0;
    assign bank_we  = cap_we ? wr_sel : 2'b00;

    // The drain may start on the edge that writes the last row: the first
    // coefficient lives in row 0 and the second never in the last row.
    assign avail    = full | done_v;

    assign advance  = !m_valid || m_ready;
    assign load     = advance && avail[rd_bank];
    assign k_last   = (next_k == K_W'(RING_DIM - 1));
    assign k_inc    = next_k + 1'b1;
    assign cur_coef = coef_of(next_k);
    assign nxt_coef = coef_of(k_inc);
    // Address the row that will be current after this edge so the lane mux is ready.
    assign rd_row   = load ? nxt_coef[K_W-1:LANE_W] : cur_coef[K_W-1:LANE_W];
    assign rd_lane  = cur_coef[LANE_W-1:0];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ntt_oser_bank #(
            .DATA_WIDTH_PER_INPUT (DATA_WIDTH_PER_INPUT),
            .INPUT_PER_CYCLE      (INPUT_PER_CYCLE),
            .ROWS                 (ROWS)
        ) u_bank (
            .clk     (clk),
            .we      (bank_we[b]),
            .wr_row  (cap_row),
            .wr_data (lane_data),
            .rd_row  (rd_row),
            .rd_lane (rd_lane),
            .rd_data (bank_rd[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_state <= C_IDLE;
            wr_bank   <= 1'b0;
            wr_row    <= '0;
            overflow  <= 1'b0;
        end else begin
            case (cap_state)
                C_IDLE: begin
                    if (frame_start) begin
                        if (bank_free) begin
                            cap_state <= C_CAPTURE;
                            wr_row    <= ROW_W'(1);
                        end else begin
                            overflow  <= 1'b1;
                        end
                    end
                end
                C_CAPTURE: begin
                    if (frame_start) begin
                        overflow <= 1'b1;
                    end
                    wr_row <= wr_row + 1'b1;
                    if (cap_done) begin
                        cap_state <= C_IDLE;
                        wr_bank   <= ~wr_bank;
                    end
                end
                default: cap_state <= C_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            full <= (full | done_v) & ~free_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drn_state <= D_IDLE;
            rd_bank   <= 1'b0;
            out_bank  <= 1'b0;
            next_k    <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
        end else begin
            case (drn_state)
                D_IDLE, D_STREAM: begin
                    if (load) begin
                        drn_state <= D_STREAM;
                        m_valid   <= 1'b1;
                        m_data    <= bank_rd[rd_bank];
                        m_last    <= k_last;
                        out_bank  <= rd_bank;
                        next_k    <= k_inc;
                        if (k_last) begin
                            rd_bank <= ~rd_bank;
                        end
                    end else if (advance) begin
                        drn_state <= D_IDLE;
                        m_valid   <= 1'b0;
                        m_last    <= 1'b0;
                    end
                end
                default: drn_state <= D_IDLE;
            endcase
        end
    end

    assign busy          = (cap_state == C_CAPTURE) || (|full);
    assign dbg_cap_state = (cap_state == C_CAPTURE);
    assign dbg_drn_state = (drn_state == D_STREAM);

endmodule

// File: tb/tb_ntt_out_serializer.sv
// Directed bench for ntt_out_serializer: timing, back-to-back frames, backpressure,
// dropped frames, reset mid-drain; expected order follows NTT_OSER_BITREV_EN.
module tb_ntt_out_serializer;

    localparam int DW   = 28;
    localparam int IPC  = 128;
    localparam int RD   = 2048;
    localparam int ROWS = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                frame_start;
    logic [IPC*DW-1:0]   lane_data;
    logic [DW-1:0]       m_data;
    logic                m_valid;
    logic                m_ready;
    logic                m_last;
    logic                busy;
    logic                overflow;
    logic                dbg_cap_state;
    logic                dbg_drn_state;

    logic [DW:0]         exp_q[$];
    int                  n_cmp = 0;
    int                  n_err = 0;
    int                  n_xfer = 0;
    int                  cyc = 0;
    int                  first_cyc = -1;
    int                  last_cyc = -1;
    logic                sf_early;
    logic                hold_pend = 1'b0;
    logic [DW-1:0]       hold_data = '0;

    ntt_out_serializer dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .lane_data     (lane_data),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .busy          (busy),
        .overflow      (overflow),
        .dbg_cap_state (dbg_cap_state),
        .dbg_drn_state (dbg_drn_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_pos(input int k);
`ifdef NTT_OSER_BITREV_EN
        int r;
        r = 0;
        for (int i = 0; i < 11; i++) begin
            if (((k >> i) & 1) != 0) r = r | (1 << (10 - i));
        end
        return r;
`else
        return k;
`endif
    endfunction

    task automatic push_frame(input int base);
        logic [DW:0] e;
        for (int k = 0; k < RD; k++) begin
            e[DW-1:0] = DW'(base + exp_pos(k));
            e[DW]     = (k == RD - 1);
            exp_q.push_back(e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame's rows; dup_row >= 1 also pulses frame_start inside the capture.
    task automatic send_frame(input int base, input int dup_row);
        sf_early = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            frame_start = (r == 0) || (r == dup_row);
            for (int l = 0; l < IPC; l++) begin
                lane_data[l*DW +: DW] = DW'(base + r*IPC + l);
            end
            tick();
            if (r < ROWS - 1 && m_valid) sf_early = 1'b1;
        end
        frame_start = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 12000 && exp_q.size() != 0; i++) tick();
        check_eq(tag, exp_q.size(), 0);
    endtask

    task automatic wait_xfer(input string tag, input int target);
        for (int i = 0; i < 8000 && n_xfer < target; i++) tick();
        check_eq(tag, n_xfer, target);
    endtask

    // ---------------- scoreboard / monitor ----------------
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    check_eq("hold_valid", m_valid, 1);
                    check_eq("hold_data", m_data, hold_data);
                end
                hold_pend = m_valid && !m_ready;
                hold_data = m_data;
                if (m_valid && m_ready) begin
                    n_xfer++;
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("beat_data", m_data, e[DW-1:0]);
                        check_eq("beat_last", m_last, e[DW]);
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int s;
        rst         = 1'b1;
        frame_start = 1'b0;
        lane_data   = '0;
        m_ready     = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_last", m_last, 0);
        check_eq("rst_m_data", m_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overflow", overflow, 0);

        // Single frame, lane value = k: first valid 16 cycles after frame_start.
        s = n_xfer;
        push_frame(0);
        send_frame(0, -1);
        check_eq("no_early_valid", sf_early, 0);
        check_eq("first_valid_t16", m_valid, 1);
        check_eq("busy_after_capture", busy, 1);
        wait_drain("drain_single");
        tick();
        check_eq("single_count", n_xfer - s, RD);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_valid", m_valid, 0);

        // Second frame_start at T+16: 4096 contiguous beats.
        s = n_xfer;
        first_cyc = -1;
        push_frame(3000);
        push_frame(7000);
        send_frame(3000, -1);
        send_frame(7000, -1);
        wait_drain("drain_b2b");
        check_eq("b2b_count", n_xfer - s, 2 * RD);
        check_eq("b2b_contiguous", last_cyc - first_cyc + 1, 2 * RD);
        check_eq("b2b_overflow", overflow, 0);

        // Backpressure for 10 cycles with k=100 on the bus.
        s = n_xfer;
        push_frame(11000);
        send_frame(11000, -1);
        wait_xfer("stall_reach", s + 100);
        m_ready = 1'b0;
        tick();
        check_eq("stall_data_k100", m_data, DW'(11000 + exp_pos(100)));
        check_eq("stall_valid", m_valid, 1);
        repeat (9) tick();
        check_eq("stall_no_xfer", n_xfer - s, 100);
        m_ready = 1'b1;
        wait_drain("drain_stall");
        check_eq("stall_count", n_xfer - s, RD);

        // frame_start at T+5 is ignored and sets overflow.
        s = n_xfer;
        push_frame(20000);
        send_frame(20000, 5);
        check_eq("ovf_capture", overflow, 1);
        wait_drain("drain_ovf");
        check_eq("ovf_count", n_xfer - s, RD);
        check_eq("ovf_sticky", overflow, 1);

        // Reset at k=700 of a drain, then a fresh frame from k=0.
        s = n_xfer;
        push_frame(30000);
        send_frame(30000, -1);
        wait_xfer("rst_reach", s + 700);
        rst = 1'b1;
        exp_q.delete();
        tick();
        check_eq("rst_mid_valid", m_valid, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_overflow", overflow, 0);
        rst = 1'b0;
        tick();
        s = n_xfer;
        push_frame(40000);
        send_frame(40000, -1);
        wait_drain("drain_after_rst");
        check_eq("after_rst_count", n_xfer - s, RD);

        // Third frame while both banks are full is dropped.
        s = n_xfer;
        m_ready = 1'b0;
        push_frame(50000);
        push_frame(60000);
        send_frame(50000, -1);
        send_frame(60000, -1);
        check_eq("full_no_ovf_yet", overflow, 0);
        send_frame(70000, -1);
        check_eq("drop_overflow", overflow, 1);
        check_eq("drop_busy", busy, 1);
        check_eq("drop_no_xfer", n_xfer - s, 0);
        m_ready = 1'b1;
        wait_drain("drain_drop");
        check_eq("drop_count", n_xfer - s, 2 * RD);
        tick();
        check_eq("drop_ovf_sticky", overflow, 1);

        // Random backpressure over one frame.
        s = n_xfer;
        begin
            int base;
            base = int'($urandom_range(0, 1 << 20));
            push_frame(base);
            fork
                send_frame(base, -1);
                begin
                    for (int i = 0; i < 12000 && exp_q.size() != 0; i++) begin
                        m_ready = 1'($urandom_range(0, 1));
                        tick();
                    end
                end
            join
        end
        m_ready = 1'b1;
        wait_drain("drain_random");
        check_eq("random_count", n_xfer - s, RD);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
